// File: rtl/data_ram_arbiter.sv
// Two-port (A/B) arbiter and access sequencer in front of a single-port data RAM.
// Each granted access takes IDLE -> ACCESS -> ACK, with all RAM controls driven from registers.
module data_ram_arbiter #(
   parameter int MEM_DEPTH = 256,
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ReqA,
   input  logic        ReqB,
   input  logic        WeA,
   input  logic        WeB,
   input  logic [15:0] AddrA,
   input  logic [15:0] AddrB,
   input  logic [15:0] WDataA,
   input  logic [15:0] WDataB,
   output logic        AckA,
   output logic        AckB,
   output logic        ErrA,
   output logic        ErrB,
   output logic [15:0] RDataA,
   output logic [15:0] RDataB,
   output logic        Busy,
   output logic [15:0] DataAddress,
   output logic        ReadMem,
   output logic        WriteMem,
   output logic [15:0] DataIn,
   input  logic [15:0] DataOut
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

   state_t      state_r;
   state_t      state_next_s;
   logic        grant_s;
   logic        grant_b_s;
   logic        last_b_r;
   logic        port_b_r;
   logic        oor_r;
   logic        sel_we_s;
   logic        sel_oor_s;
   logic [15:0] sel_addr_s;
   logic [15:0] sel_wdata_s;

   // Next-state and winner selection; LastGrant resets to B so A wins the first tie
   always_comb begin
      state_next_s = state_r;
      grant_s      = 1'b0;
      grant_b_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ReqA || ReqB) begin
               grant_s      = 1'b1;
               state_next_s = ST_ACCESS;
               if (ReqA && ReqB) begin
                  grant_b_s = FIXED_PRI ? 1'b0 : ~last_b_r;
               end else begin
                  grant_b_s = ReqB;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACCESS: state_next_s = ST_ACCESS == state_r ? ST_ACK : ST_IDLE;
         ST_ACK:    state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // Command mux for the winning port, with the full-width range check
   always_comb begin
      sel_we_s    = grant_b_s ? WeB    : WeA;
      sel_addr_s  = grant_b_s ? AddrB  : AddrA;
      sel_wdata_s = grant_b_s ? WDataB : WDataA;
      sel_oor_s   = ({1'b0, sel_addr_s} >= DEPTH_L);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Latched command, RAM strobes, read capture and Ack/Err pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b_r    <= 1'b1;
         port_b_r    <= 1'b0;
         oor_r       <= 1'b0;
         DataAddress <= 16'h0000;
         DataIn      <= 16'h0000;
         ReadMem     <= 1'b0;
         WriteMem    <= 1'b0;
         Busy        <= 1'b0;
         AckA        <= 1'b0;
         AckB        <= 1'b0;
         ErrA        <= 1'b0;
         ErrB        <= 1'b0;
         RDataA      <= 16'h0000;
         RDataB      <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  last_b_r    <= grant_b_s;
                  port_b_r    <= grant_b_s;
                  oor_r       <= sel_oor_s;
                  DataAddress <= sel_addr_s;
                  DataIn      <= sel_wdata_s;
                  WriteMem    <= sel_we_s & ~sel_oor_s;
                  ReadMem     <= ~sel_we_s & ~sel_oor_s;
                  Busy        <= 1'b1;
               end
            end
            ST_ACCESS: begin
               // ReadMem already encodes "in-range read", so an out-of-range read leaves RData alone
               if (ReadMem && port_b_r) begin
                  RDataB <= DataOut;
               end
               if (ReadMem && !port_b_r) begin
                  RDataA <= DataOut;
               end
               ReadMem  <= 1'b0;
               WriteMem <= 1'b0;
               AckA     <= ~port_b_r;
               AckB     <= port_b_r;
               ErrA     <= ~port_b_r & oor_r;
               ErrB     <= port_b_r & oor_r;
            end
            ST_ACK: begin
               AckA <= 1'b0;
               AckB <= 1'b0;
               ErrA <= 1'b0;
               ErrB <= 1'b0;
               Busy <= 1'b0;
            end
            default: begin
               ReadMem  <= 1'b0;
               WriteMem <= 1'b0;
               Busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: a round-robin instance and a fixed-priority instance
// share stimulus, each with its own 256x16 RAM model preloaded with {8'hA5, addr}.
module tb_data_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_clr = 1'b1;
   logic        ReqA = 1'b0, ReqB = 1'b0, WeA = 1'b0, WeB = 1'b0;
   logic [15:0] AddrA = 16'h0000, AddrB = 16'h0000, WDataA = 16'h0000, WDataB = 16'h0000;

   logic        AckA, AckB, ErrA, ErrB, Busy, ReadMem, WriteMem;
   logic [15:0] RDataA, RDataB, DataAddress, DataIn, DataOut;
   logic        AckA2, AckB2, ErrA2, ErrB2, Busy2, ReadMem2, WriteMem2;
   logic [15:0] RDataA2, RDataB2, DataAddress2, DataIn2, DataOut2;

   logic [15:0] mem [256];
   logic [15:0] mem2 [256];
   int          total = 0;
   int          bad = 0;
   logic [11:0] seq_a, seq_b, seq_a2, seq_b2;

   always #5 clk = ~clk;

   data_ram_arbiter #(.MEM_DEPTH(256), .FIXED_PRI(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
      .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
      .AckA(AckA), .AckB(AckB), .ErrA(ErrA), .ErrB(ErrB), .RDataA(RDataA), .RDataB(RDataB),
      .Busy(Busy), .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
      .DataIn(DataIn), .DataOut(DataOut));

   data_ram_arbiter #(.MEM_DEPTH(256), .FIXED_PRI(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
      .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
      .AckA(AckA2), .AckB(AckB2), .ErrA(ErrA2), .ErrB(ErrB2), .RDataA(RDataA2), .RDataB(RDataB2),
      .Busy(Busy2), .DataAddress(DataAddress2), .ReadMem(ReadMem2), .WriteMem(WriteMem2),
      .DataIn(DataIn2), .DataOut(DataOut2));

   assign DataOut  = ReadMem  ? mem[DataAddress[7:0]]   : 16'h0000;
   assign DataOut2 = ReadMem2 ? mem2[DataAddress2[7:0]] : 16'h0000;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) begin
            mem[i]  <= {8'hA5, 8'(i)};
            mem2[i] <= {8'hA5, 8'(i)};
         end
      end else begin
         if (WriteMem)  mem[DataAddress[7:0]]   <= DataIn;
         if (WriteMem2) mem2[DataAddress2[7:0]] <= DataIn2;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One single-port access starting from IDLE; returns with Req dropped after the Ack edge.
   task automatic xfer(input string tag, input logic pb, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic err, input logic [15:0] exp_rd);
      @(posedge clk); #1;
      if (pb) begin
         ReqB = 1'b1; WeB = we; AddrB = addr; WDataB = wd;
      end else begin
         ReqA = 1'b1; WeA = we; AddrA = addr; WDataA = wd;
      end
      @(negedge clk);
      chk({tag, "_c0_busy"}, {31'd0, Busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_c1_strobe"}, {30'd0, WriteMem, ReadMem}, {30'd0, we & ~err, ~we & ~err});
      chk({tag, "_c1_addr"}, {16'd0, DataAddress}, {16'd0, addr});
      @(negedge clk);
      chk({tag, "_c2_ackerr"}, {28'd0, AckA, AckB, ErrA, ErrB},
          pb ? {28'd0, 1'b0, 1'b1, 1'b0, err} : {28'd0, 1'b1, 1'b0, err, 1'b0});
      chk({tag, "_c2_strobe"}, {30'd0, WriteMem, ReadMem}, 32'd0);
      chk({tag, "_c2_rdata"}, {16'd0, pb ? RDataB : RDataA}, {16'd0, exp_rd});
      @(posedge clk); #1;
      ReqA = 1'b0; ReqB = 1'b0;
   endtask

   initial begin
      // reset held: inputs toggle, everything stays 0
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         mem_clr = 1'b0;
         ReqA = ~ReqA; ReqB = 1'b1; WeA = ~WeA; WeB = 1'b1; AddrA = AddrA + 16'd3;
         @(negedge clk);
         chk("rst_ctl", {18'd0, AckA, AckB, ErrA, ErrB, ReadMem, WriteMem, Busy,
             AckA2, AckB2, ErrA2, ErrB2, ReadMem2, WriteMem2, Busy2}, 32'd0);
         chk("rst_bus", {DataAddress, DataIn}, 32'd0);
         chk("rst_rdata", {RDataA, RDataB}, 32'd0);
      end
      ReqA = 1'b0; ReqB = 1'b0; WeA = 1'b0; WeB = 1'b0; AddrA = 16'h0000;
      @(negedge clk); rst_n = 1'b1;

      // A write 0x0010 <- 0xBEEF, then A read back
      @(posedge clk); #1;
      ReqA = 1'b1; WeA = 1'b1; AddrA = 16'h0010; WDataA = 16'hBEEF;
      @(negedge clk);
      chk("wr_c0_wm", {31'd0, WriteMem}, 32'd0);
      @(posedge clk); #1;
      AddrA = 16'h0011; WDataA = 16'h0000;
      @(negedge clk);
      chk("wr_c1_wm", {31'd0, WriteMem}, 32'd1);
      chk("wr_c1_bus", {DataAddress, DataIn}, 32'h0010BEEF);
      chk("wr_c1_busy", {31'd0, Busy}, 32'd1);
      @(negedge clk);
      chk("wr_c2_ack", {29'd0, AckA, ErrA, WriteMem}, 32'b100);
      @(posedge clk); #1;
      WeA = 1'b0; AddrA = 16'h0010;
      @(negedge clk);
      chk("rd_c3_idle", {29'd0, AckA, ReadMem, Busy}, 32'd0);
      @(negedge clk);
      chk("rd_c4_rm", {31'd0, ReadMem}, 32'd1);
      @(negedge clk);
      chk("rd_c5_ack", {31'd0, AckA}, 32'd1);
      chk("rd_c5_data", {16'd0, RDataA}, 32'h0000BEEF);
      @(posedge clk); #1;
      ReqA = 1'b0;

      // tie on the first cycle after reset: A first, then B
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      ReqA = 1'b1; WeA = 1'b0; AddrA = 16'h0030;
      ReqB = 1'b1; WeB = 1'b0; AddrB = 16'h0031;
      @(negedge clk);
      @(negedge clk);
      chk("tie_c1_addr", {16'd0, DataAddress}, 32'h00000030);
      @(negedge clk);
      chk("tie_c2_ack", {30'd0, AckA, AckB}, 32'b10);
      chk("tie_c2_rda", {16'd0, RDataA}, 32'h0000A530);
      @(posedge clk); #1;
      ReqA = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("tie_c4_addr", {16'd0, DataAddress}, 32'h00000031);
      @(negedge clk);
      chk("tie_c5_ack", {30'd0, AckA, AckB}, 32'b01);
      chk("tie_c5_rd", {RDataA, RDataB}, 32'hA530A531);
      @(posedge clk); #1;
      ReqB = 1'b0;

      // range boundary and out-of-range accesses
      xfer("rd_a_ff",  1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'hA5FF);
      xfer("oor_rd_a", 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'hA5FF);
      xfer("oor_wr_b", 1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b1, 16'hA531);
      xfer("rd_b_0",   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA500);

      // both requests held: round-robin alternates, fixed priority serves only A
      @(posedge clk); #1;
      ReqA = 1'b1; WeA = 1'b0; AddrA = 16'h0030;
      ReqB = 1'b1; WeB = 1'b0; AddrB = 16'h0031;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         seq_a[k] = AckA; seq_b[k] = AckB; seq_a2[k] = AckA2; seq_b2[k] = AckB2;
      end
      chk("rr_acka", {20'd0, seq_a}, 32'h104);
      chk("rr_ackb", {20'd0, seq_b}, 32'h820);
      chk("fp_acka", {20'd0, seq_a2}, 32'h924);
      chk("fp_ackb", {20'd0, seq_b2}, 32'h000);
      @(posedge clk); #1;
      ReqA = 1'b0; ReqB = 1'b0;

      // reset during a write's ACCESS cycle
      @(posedge clk); #1;
      ReqA = 1'b1; WeA = 1'b1; AddrA = 16'h0020; WDataA = 16'h1234;
      @(negedge clk);
      @(negedge clk);
      chk("rst_wr_c1_wm", {31'd0, WriteMem}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_wr_drop", {30'd0, WriteMem, Busy}, 32'd0);
      WeA = 1'b0; ReqB = 1'b1; WeB = 1'b0; AddrB = 16'h0031;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_wr_noack", {31'd0, AckA}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tie_c1", {15'd0, ReadMem, DataAddress}, 32'h00010020);
      @(negedge clk);
      chk("rst_tie_ack", {30'd0, AckA, AckB}, 32'b10);
      chk("rst_tie_old", {16'd0, RDataA}, 32'h0000A520);
      @(posedge clk); #1;
      ReqA = 1'b0; ReqB = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
